frame_scaler: RTL and testbench

- Parametrised successor to the fixed 2x zoom datapath in the coprocessor. Reads a source image from a fixed-latency synchronous memory (ROM/RAM) and writes the scaled result into the destination frame RAM that the VGA path reads.
- Supports four selectable modes: copy, 2x replicate, 2x decimate, 2x block average.
- Sits between the top-level controller (START/DONE handshake) and the source and destination memories.

---
 rtl/frame_scaler.sv | 209 ++++++++++++++++++++
 tb/tb_frame_scaler.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_scaler.sv
// Frame scaler: copy, 2x replicate, 2x decimate or 2x block average from a fixed-latency
// source memory into the destination frame RAM. Define FRAME_SCALER_ROUND_EN for round-half-up averaging.

module frame_scaler #(
    parameter int PIX_W  = 8,
    parameter int SRC_W  = 160,
    parameter int SRC_H  = 120,
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 17
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic              ABORT,
    input  logic [1:0]        MODE,
    output logic              BUSY,
    output logic              DONE,
    output logic [ADDR_W-1:0] SRC_ADDR,
    input  logic [PIX_W-1:0]  SRC_DATA,
    output logic [ADDR_W-1:0] DST_ADDR,
    output logic [PIX_W-1:0]  DST_DATA,
    output logic              DST_WREN
);

    localparam int X_W   = $clog2(2 * SRC_W);
    localparam int Y_W   = $clog2(2 * SRC_H);
    localparam int WC_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int ACC_W = PIX_W + 2;

    if (SRC_W < 2 || SRC_W % 2 != 0) begin : g_chk_w
        $error("frame_scaler: SRC_W must be even and non-zero");
    end
    if (SRC_H < 2 || SRC_H % 2 != 0) begin : g_chk_h
        $error("frame_scaler: SRC_H must be even and non-zero");
    end
    if (RD_LAT < 1) begin : g_chk_lat
        $error("frame_scaler: RD_LAT must be at least 1");
    end
    // Replicate mode produces the largest address range: 4 * SRC_W * SRC_H pixels.
    if (longint'(4) * SRC_W * SRC_H > (longint'(1) << ADDR_W)) begin : g_chk_addr
        $error("frame_scaler: ADDR_W too narrow for the replicated frame");
    end

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE} state_e;
    typedef enum logic [1:0] {M_COPY, M_REPL, M_DECI, M_AVG} mode_e;

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [X_W-1:0]    ox_q, ox_d;
    logic [Y_W-1:0]    oy_q, oy_d;
    logic [1:0]        tap_q, tap_d;
    logic [WC_W-1:0]   wait_q, wait_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ADDR_W-1:0] dst_addr_q, dst_addr_d;
    logic [ADDR_W-1:0] src_addr_q, src_addr_d;

    logic [X_W-1:0]    out_w_m1, sx;
    logic [Y_W-1:0]    out_h_m1, sy;
    logic [1:0]        taps_m1;
    logic [ADDR_W-1:0] tap_addr;
    logic [ACC_W-1:0]  acc_sum;
    logic [PIX_W-1:0]  avg_pix;

    // Output geometry and source tap coordinates for the latched mode.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        out_w_m1 = X_W'(SRC_W - 1);
        out_h_m1 = Y_W'(SRC_H - 1);
        taps_m1  = 2'd0;
        sx       = ox_q;
        sy       = oy_q;
        case (mode_q)
            M_REPL: begin
                out_w_m1 = X_W'(2 * SRC_W - 1);
                out_h_m1 = Y_W'(2 * SRC_H - 1);
                sx       = ox_q >> 1;
                sy       = oy_q >> 1;
            end
            M_DECI: begin
                out_w_m1 = X_W'(SRC_W / 2 - 1);
                out_h_m1 = Y_W'(SRC_H / 2 - 1);
                sx       = ox_q << 1;
                sy       = oy_q << 1;
            end
            M_AVG: begin
                out_w_m1 = X_W'(SRC_W / 2 - 1);
                out_h_m1 = Y_W'(SRC_H / 2 - 1);
                taps_m1  = 2'd3;
                sx       = (ox_q << 1) | X_W'(tap_q[0]);
                sy       = (oy_q << 1) | Y_W'(tap_q[1]);
            end
            default: ;
        endcase
    end

    assign tap_addr = ADDR_W'(sy) * ADDR_W'(SRC_W) + ADDR_W'(sx);
    assign acc_sum  = ((tap_q == 2'd0) ? '0 : acc_q) + ACC_W'(SRC_DATA);

`ifdef FRAME_SCALER_ROUND_EN
    logic [ACC_W:0] rnd_sum;
    assign rnd_sum = {1'b0, acc_q} + (ACC_W + 1)'(2);
    assign avg_pix = rnd_sum[ACC_W] ? '1 : PIX_W'(rnd_sum >> 2);
`else
    assign avg_pix = PIX_W'(acc_q >> 2);
`endif

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        tap_d      = tap_q;
        wait_d     = wait_q;
        acc_d      = acc_q;
        dst_addr_d = dst_addr_q;
        src_addr_d = src_addr_q;
        case (state_q)
            S_IDLE: begin
                if (START && !ABORT) begin
                    state_d    = S_READ;
                    mode_d     = mode_e'(MODE);
                    ox_d       = '0;
                    oy_d       = '0;
                    tap_d      = '0;
                    dst_addr_d = '0;
                end
            end
            S_READ: begin
                src_addr_d = tap_addr;
                wait_d     = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == WC_W'(RD_LAT - 1)) begin
                    acc_d = acc_sum;
                    if (tap_q == taps_m1) begin
                        tap_d   = '0;
                        state_d = S_WRITE;
                    end else begin
                        tap_d   = tap_q + 2'd1;
                        state_d = S_READ;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WRITE: begin
                dst_addr_d = dst_addr_q + 1'b1;
                state_d    = S_READ;
                if (ox_q == out_w_m1) begin
                    ox_d = '0;
                    if (oy_q == out_h_m1) begin
                        oy_d       = '0;
                        dst_addr_d = '0;
                        state_d    = S_DONE;
                    end else begin
                        oy_d = oy_q + 1'b1;
                    end
                end else begin
                    ox_d = ox_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort drops the frame from any active state; the counters restart with the next frame.
        if (ABORT && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            ox_d       = '0;
            oy_d       = '0;
            tap_d      = '0;
            wait_d     = '0;
            dst_addr_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            mode_q     <= M_COPY;
            ox_q       <= '0;
            oy_q       <= '0;
            tap_q      <= '0;
            wait_q     <= '0;
            acc_q      <= '0;
            dst_addr_q <= '0;
            src_addr_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
            state_q    <= state_d;
            mode_q     <= mode_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            tap_q      <= tap_d;
            wait_q     <= wait_d;
            acc_q      <= acc_d;
            dst_addr_q <= dst_addr_d;
            src_addr_q <= src_addr_d;
        end
    end

    assign BUSY     = (state_q == S_READ) || (state_q == S_WAIT) || (state_q == S_WRITE);
    assign DONE     = (state_q == S_DONE);
    assign DST_WREN = (state_q == S_WRITE);
    assign SRC_ADDR = (state_q == S_READ) ? tap_addr : src_addr_q;
    assign DST_ADDR = dst_addr_q;
    assign DST_DATA = (mode_q == M_AVG) ? avg_pix : acc_q[PIX_W-1:0];

endmodule

// File: tb/tb_frame_scaler.sv
// Self-checking bench for frame_scaler: two 4x2 instances (RD_LAT 1 and 3), a latency-accurate
// source memory, and an arithmetic reference model of each scaling mode.

module tb_frame_scaler;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] cyc;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_s    [2];
    logic       abort_s    [2];
    logic [1:0] mode_s     [2];
    logic       busy_s     [2];
    logic       done_s     [2];
    logic       wren_s     [2];
    logic [7:0] src_addr_s [2];
    logic [7:0] src_data_s [2];
    logic [7:0] dst_addr_s [2];
    logic [7:0] dst_data_s [2];

    logic [7:0] img [2][256];
    wr_t        got_q [2][$];
    int         done_cnt [2] = '{0, 0};
    int         done_cyc [2] = '{0, 0};
    int         busy_tot [2] = '{0, 0};
    int         cyc       = 0;
    int         checks    = 0;
    int         failures  = 0;
    int         last_base = 0;
    int         exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [7:0] pipe [3];

        frame_scaler #(
            .PIX_W (8),
            .SRC_W (4),
            .SRC_H (2),
            .RD_LAT(LAT),
            .ADDR_W(8)
        ) u_dut (
            .CLK     (clk),
            .RESET   (rst),
            .START   (start_s[g]),
            .ABORT   (abort_s[g]),
            .MODE    (mode_s[g]),
            .BUSY    (busy_s[g]),
            .DONE    (done_s[g]),
            .SRC_ADDR(src_addr_s[g]),
            .SRC_DATA(src_data_s[g]),
            .DST_ADDR(dst_addr_s[g]),
            .DST_DATA(dst_data_s[g]),
            .DST_WREN(wren_s[g])
        );

        // Synchronous source memory: data for an address appears LAT cycles after it is presented.
        always @(posedge clk) begin
            pipe[0] <= img[g][src_addr_s[g]];
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign src_data_s[g] = pipe[LAT-1];

        always @(negedge clk) begin
            if (wren_s[g]) got_q[g].push_back({32'(dst_addr_s[g]), 32'(dst_data_s[g]), 32'(cyc)});
            if (done_s[g]) begin
                done_cnt[g] = done_cnt[g] + 1;
                done_cyc[g] = cyc;
            end
            if (busy_s[g]) busy_tot[g] = busy_tot[g] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic int px(input int g, input int x, input int y);
        return int'(img[g][y * 4 + x]);
    endfunction

    // Reference: walk the output raster and compute each pixel straight from the mode's definition.
    function automatic void build_exp(input int g, input int mode);
        int ow, oh, s;
        exp_q.delete();
        ow = (mode == 0) ? 4 : (mode == 1) ? 8 : 2;
        oh = (mode == 0) ? 2 : (mode == 1) ? 4 : 1;
        for (int oy = 0; oy < oh; oy++) begin
            for (int ox = 0; ox < ow; ox++) begin
                case (mode)
                    0: exp_q.push_back(px(g, ox, oy));
                    1: exp_q.push_back(px(g, ox / 2, oy / 2));
                    2: exp_q.push_back(px(g, 2 * ox, 2 * oy));
                    default: begin
                        s = px(g, 2 * ox, 2 * oy) + px(g, 2 * ox + 1, 2 * oy)
                          + px(g, 2 * ox, 2 * oy + 1) + px(g, 2 * ox + 1, 2 * oy + 1);
`ifdef FRAME_SCALER_ROUND_EN
                        exp_q.push_back(((s + 2) / 4 > 255) ? 255 : (s + 2) / 4);
`else
                        exp_q.push_back(s / 4);
`endif
                    end
                endcase
            end
        end
    endfunction

    task automatic fill_ramp(input int g);
        for (int i = 0; i < 8; i++) img[g][i] = 8'(i);
    endtask

    task automatic fill_rand(input int g);
        for (int i = 0; i < 8; i++) img[g][i] = 8'($urandom);
    endtask

    task automatic check_zero(input string tag, input int g);
        check({tag, "_busy"}, 32'(busy_s[g]), 0);
        check({tag, "_done"}, 32'(done_s[g]), 0);
        check({tag, "_wren"}, 32'(wren_s[g]), 0);
        check({tag, "_src_addr"}, 32'(src_addr_s[g]), 0);
        check({tag, "_dst_addr"}, 32'(dst_addr_s[g]), 0);
        check({tag, "_dst_data"}, 32'(dst_data_s[g]), 0);
    endtask

    // Runs one frame; if poke is non-zero, a second START with another MODE is pulsed at that cycle.
    task automatic run_frame(input int g, input int mode, input string tag, input int poke);
        int  base_wr, base_done, base_busy, n, cpp, c_s, rel;
        wr_t w;
        bit  seen;
        build_exp(g, mode);
        n         = exp_q.size();
        cpp       = ((mode == 3) ? 4 : 1) * (1 + lat_of(g)) + 1;
        base_wr   = got_q[g].size();
        base_done = done_cnt[g];
        base_busy = busy_tot[g];
        @(negedge clk);
        mode_s[g]  = 2'(mode);
        start_s[g] = 1'b1;
        @(posedge clk);
        #1;
        start_s[g] = 1'b0;
        c_s        = cyc;
        seen       = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            #1;
            rel = cyc - c_s + 1;
            if (poke != 0 && rel == poke) begin
                start_s[g] = 1'b1;
                mode_s[g]  = 2'(3 - mode);
            end else begin
                start_s[g] = 1'b0;
            end
            if (done_cnt[g] != base_done) seen = 1'b1;
        end
        start_s[g] = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 1);
        repeat (4) @(negedge clk);
        #1;
        check({tag, "_nwrites"}, got_q[g].size() - base_wr, n);
        check({tag, "_ndone"}, done_cnt[g] - base_done, 1);
        check({tag, "_busy_cycles"}, busy_tot[g] - base_busy, n * cpp);
        check({tag, "_done_cycle"}, done_cyc[g] - c_s + 1, n * cpp + 1);
        for (int k = 0; k < n && base_wr + k < got_q[g].size(); k++) begin
            w = got_q[g][base_wr + k];
            check($sformatf("%s_addr%0d", tag, k), w.addr, k);
            check($sformatf("%s_data%0d", tag, k), w.data, exp_q[k]);
            check($sformatf("%s_cyc%0d", tag, k), int'(w.cyc) - c_s + 1, (k + 1) * cpp);
        end
        last_base = base_wr;
    endtask

    initial begin
        int  base_wr, base_done, g, m;
        bit  seen;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            abort_s[i] = 1'b0;
            mode_s[i]  = 2'd0;
            for (int j = 0; j < 256; j++) img[i][j] = 8'd0;
        end
        #12;
        check_zero("reset0", 0);
        check_zero("reset1", 1);
        @(negedge clk);
        rst = 1'b0;

        fill_ramp(0);
        run_frame(0, 0, "copy", 0);

        run_frame(0, 1, "repl", 0);
        check("repl_a0", got_q[0][last_base + 0].data, 0);
        check("repl_a1", got_q[0][last_base + 1].data, 0);
        check("repl_a8", got_q[0][last_base + 8].data, 0);
        check("repl_a9", got_q[0][last_base + 9].data, 0);
        check("repl_a2", got_q[0][last_base + 2].data, 1);
        check("repl_a31", got_q[0][last_base + 31].data, 7);

        img[0][0] = 8'd10; img[0][1] = 8'd11; img[0][4] = 8'd12; img[0][5] = 8'd13;
        img[0][2] = 8'd255; img[0][3] = 8'd255; img[0][6] = 8'd255; img[0][7] = 8'd255;
        run_frame(0, 3, "avg", 0);
`ifdef FRAME_SCALER_ROUND_EN
        check("avg_block0", got_q[0][last_base].data, 12);
`else
        check("avg_block0", got_q[0][last_base].data, 11);
`endif
        check("avg_block1", got_q[0][last_base + 1].data, 255);

        fill_rand(1);
        img[1][2] = img[1][0] ^ 8'h5a;
        run_frame(1, 2, "lat3_deci", 0);
        check("lat3_pix0", got_q[1][last_base].data, 32'(img[1][0]));
        check("lat3_pix1", got_q[1][last_base + 1].data, 32'(img[1][2]));

        for (int r = 0; r < 6; r++) begin
            g = int'($urandom_range(0, 1));
            m = int'($urandom_range(0, 3));
            fill_rand(g);
            run_frame(g, m, $sformatf("rnd%0d_g%0d_m%0d", r, g, m), 0);
        end

        fill_ramp(0);
        run_frame(0, 0, "start_busy", 10);

        base_wr   = got_q[0].size();
        base_done = done_cnt[0];
        @(negedge clk);
        mode_s[0]  = 2'd0;
        start_s[0] = 1'b1;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        seen       = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (got_q[0].size() - base_wr >= 3) seen = 1'b1;
        end
        check("abort_third_write", 32'(seen), 1);
        @(negedge clk);
        #1;
        abort_s[0] = 1'b1;
        @(posedge clk);
        #1;
        abort_s[0] = 1'b0;
        check("abort_busy_next", 32'(busy_s[0]), 0);
        repeat (40) @(negedge clk);
        #1;
        check("abort_nwrites", got_q[0].size() - base_wr, 3);
        check("abort_ndone", done_cnt[0] - base_done, 0);

        base_wr = got_q[0].size();
        @(negedge clk);
        start_s[0] = 1'b1;
        abort_s[0] = 1'b1;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        abort_s[0] = 1'b0;
        check("abort_start_idle_busy", 32'(busy_s[0]), 0);
        repeat (10) @(negedge clk);
        #1;
        check("abort_start_idle_nwr", got_q[0].size() - base_wr, 0);

        run_frame(0, 1, "post_abort", 0);

        base_wr   = got_q[0].size();
        base_done = done_cnt[0];
        @(negedge clk);
        mode_s[0]  = 2'd1;
        start_s[0] = 1'b1;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        check("midrst_busy_before", 32'(busy_s[0]), 1);
        rst = 1'b1;
        #1;
        check_zero("midrst", 0);
        @(negedge clk);
        rst = 1'b0;
        base_wr = got_q[0].size();
        repeat (30) @(negedge clk);
        #1;
        check("midrst_nwrites", got_q[0].size() - base_wr, 0);
        check("midrst_ndone", done_cnt[0] - base_done, 0);
        check("midrst_busy_after", 32'(busy_s[0]), 0);

        fill_rand(0);
        run_frame(0, 3, "post_reset", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
